// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared types and constants for the coffee vending controller
package coffee_pkg;

    // Controller states: waiting, valve open, emitting a coin, spacing between coins
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2,
        ST_GAP      = 2'd3
    } disp_state_t;

    // Request codes on seleccion
    localparam logic [1:0] SEL_DRINK0 = 2'd0;
    localparam logic [1:0] SEL_DRINK1 = 2'd1;
    localparam logic [1:0] SEL_DRINK2 = 2'd2;
    localparam logic [1:0] SEL_CANCEL = 2'd3;

    // Coin values in 100-colon units
    localparam logic [3:0] COIN_500_UNITS = 4'd5;
    localparam logic [3:0] COIN_100_UNITS = 4'd1;

    // Default drink prices in 100-colon units; shared with the coin adder so the
    // 4-bit balance range always covers every price
    localparam int DEF_PRICE_0 = 3;
    localparam int DEF_PRICE_1 = 5;
    localparam int DEF_PRICE_2 = 7;

endpackage

// File: rtl/change_emitter.sv
// rtl/change_emitter.sv - holds pending change and emits spaced 500/100 coin pulses
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            load i_amount into the pending change
//   i_amount[3:0]      change to pay, 100-colon units
//   i_emit             pay one coin on this edge (largest coin first)
//   o_done             no change pending
//   o_gap_done         coin spacing interval has elapsed
//   o_moneda_500       one-cycle 500 coin pulse
//   o_moneda_100       one-cycle 100 coin pulse
module change_emitter
    import coffee_pkg::*;
#(
    parameter int COIN_GAP = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_amount,
    input  logic       i_emit,
    output logic       o_done,
    output logic       o_gap_done,
    output logic       o_moneda_500,
    output logic       o_moneda_100
);

    localparam int GW = (COIN_GAP > 2) ? $clog2(COIN_GAP) : 1;

    logic [3:0]    r_cambio;
    logic [GW-1:0] r_gap_cnt;
    logic          r_moneda_500;
    logic          r_moneda_100;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cambio     <= 4'd0;
            r_gap_cnt    <= '0;
            r_moneda_500 <= 1'b0;
            r_moneda_100 <= 1'b0;
        end else begin
            r_moneda_500 <= 1'b0;
            r_moneda_100 <= 1'b0;
            if (i_start) begin
                r_cambio <= i_amount;
            end else if (i_emit) begin
                if (r_cambio >= COIN_500_UNITS) begin
                    r_moneda_500 <= 1'b1;
                    r_cambio     <= r_cambio - COIN_500_UNITS;
                end else if (r_cambio != 4'd0) begin
                    r_moneda_100 <= 1'b1;
                    r_cambio     <= r_cambio - COIN_100_UNITS;
                end
            end
            // The emitting edge plus COIN_GAP-1 waiting edges (the last of which
            // returns to CHANGE) put coin pulses exactly COIN_GAP cycles apart.
            if (i_emit) begin
                r_gap_cnt <= GW'(COIN_GAP - 2);
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
        end
    end

    assign o_done       = (r_cambio == 4'd0);
    assign o_gap_done   = (r_gap_cnt == '0);
    assign o_moneda_500 = r_moneda_500;
    assign o_moneda_100 = r_moneda_100;

endmodule

// File: rtl/coffee_dispense_ctrl.sv
// rtl/coffee_dispense_ctrl.sv - drink vend / cancel controller consuming the coin balance
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_saldo[3:0]          current balance from the coin adder, 100-colon units
//   i_sel_valid           request strobe, honoured only while idle
//   i_seleccion[1:0]      0..2 drink, 3 cancel/refund
//   o_aceptada            one-cycle pulse clearing the adder balance
//   o_bebida[2:0]         one-hot drink valve held for the dispense window
//   o_moneda_500/100      one-cycle coin return pulses
//   o_insuficiente        one-cycle pulse when balance is below the price
//   o_busy                high whenever not idle
module coffee_dispense_ctrl
    import coffee_pkg::*;
#(
    parameter int PRICE_0         = DEF_PRICE_0,
    parameter int PRICE_1         = DEF_PRICE_1,
    parameter int PRICE_2         = DEF_PRICE_2,
    parameter int DISPENSE_CYCLES = 8,
    parameter int COIN_GAP        = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_saldo,
    input  logic       i_sel_valid,
    input  logic [1:0] i_seleccion,
    output logic       o_aceptada,
    output logic [2:0] o_bebida,
    output logic       o_moneda_500,
    output logic       o_moneda_100,
    output logic       o_insuficiente,
    output logic       o_busy
);

    localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    disp_state_t   r_state;
    logic [DW-1:0] r_disp_cnt;
    logic          r_aceptada;
    logic [2:0]    r_bebida;
    logic          r_insuficiente;
    logic          r_busy;

    logic [3:0]    w_price;
    logic          w_is_cancel;
    logic          w_accept;
    logic [3:0]    w_amount;
    logic          w_emit;
    logic          w_done;
    logic          w_gap_done;

    always_comb begin
        w_price = 4'(PRICE_0);
        case (i_seleccion)
            SEL_DRINK1: w_price = 4'(PRICE_1);
            SEL_DRINK2: w_price = 4'(PRICE_2);
            default:    w_price = 4'(PRICE_0);
        endcase
    end

    // A cancel with nothing inserted is a no-op; a drink needs enough balance.
    assign w_is_cancel = (i_seleccion == SEL_CANCEL);
    assign w_accept    = (r_state == ST_IDLE) && i_sel_valid &&
                         (w_is_cancel ? (i_saldo != 4'd0) : (i_saldo >= w_price));
    assign w_amount    = w_is_cancel ? i_saldo : (i_saldo - w_price);
    assign w_emit      = (r_state == ST_CHANGE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_disp_cnt     <= '0;
            r_aceptada     <= 1'b0;
            r_bebida       <= 3'b000;
            r_insuficiente <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_aceptada     <= 1'b0;
            r_insuficiente <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_sel_valid) begin
                        if (w_accept) begin
                            r_aceptada <= 1'b1;
                            r_busy     <= 1'b1;
                            if (w_is_cancel) begin
                                r_state <= ST_CHANGE;
                            end else begin
                                r_bebida   <= 3'b001 << i_seleccion;
                                r_disp_cnt <= DW'(DISPENSE_CYCLES - 1);
                                r_state    <= ST_DISPENSE;
                            end
                        end else if (!w_is_cancel) begin
                            r_insuficiente <= 1'b1;
                        end
                    end
                end
                ST_DISPENSE: begin
                    if (r_disp_cnt == '0) begin
                        r_bebida <= 3'b000;
                        if (w_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_CHANGE;
                        end
                    end else begin
                        r_disp_cnt <= r_disp_cnt - DW'(1);
                    end
                end
                ST_CHANGE: begin
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (w_gap_done) begin
                        if (w_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_CHANGE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    change_emitter #(
        .COIN_GAP (COIN_GAP)
    ) u_change_emitter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (w_accept),
        .i_amount     (w_amount),
        .i_emit       (w_emit),
        .o_done       (w_done),
        .o_gap_done   (w_gap_done),
        .o_moneda_500 (o_moneda_500),
        .o_moneda_100 (o_moneda_100)
    );

    assign o_aceptada     = r_aceptada;
    assign o_bebida       = r_bebida;
    assign o_insuficiente = r_insuficiente;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// tb/tb_coffee_dispense_ctrl.sv - self-checking bench for coffee_dispense_ctrl
module tb_coffee_dispense_ctrl;

    localparam int P0 = 3;
    localparam int P1 = 5;
    localparam int P2 = 7;
    localparam int D  = 8;
    localparam int G  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] saldo;
    logic       sel_valid;
    logic [1:0] seleccion;
    logic       aceptada;
    logic [2:0] bebida;
    logic       moneda_500;
    logic       moneda_100;
    logic       insuficiente;
    logic       busy;
    logic [7:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign obs = {aceptada, bebida, moneda_500, moneda_100, insuficiente, busy};

    coffee_dispense_ctrl #(
        .PRICE_0         (P0),
        .PRICE_1         (P1),
        .PRICE_2         (P2),
        .DISPENSE_CYCLES (D),
        .COIN_GAP        (G)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_saldo        (saldo),
        .i_sel_valid    (sel_valid),
        .i_seleccion    (seleccion),
        .o_aceptada     (aceptada),
        .o_bebida       (bebida),
        .o_moneda_500   (moneda_500),
        .o_moneda_100   (moneda_100),
        .o_insuficiente (insuficiente),
        .o_busy         (busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed={acc,beb,m500,m100,ins,busy}=%b expected=%b", tag, got, exp);
        end
    endtask

    // Reference: derive the whole per-cycle output timeline of one request from
    // the vending rules (price check, change split into 500s then 100s, fixed
    // dispense window, fixed coin spacing), then compare cycle by cycle while
    // scrambling saldo and poking sel_valid whenever the machine should be busy.
    task automatic run_req(input string tag, input int s, input int k, input bit hammer);
        int   price;
        bit   acc;
        bit   ins;
        int   c;
        int   first;
        int   n500;
        int   ncoin;
        int   busy_end;
        int   len;
        int   coin_t[$];
        bit   coin_big[$];
        logic [7:0] e;

        price = (k == 0) ? P0 : (k == 1) ? P1 : P2;
        if (k == 3) begin
            acc   = (s != 0);
            ins   = 1'b0;
            c     = s;
            first = 1;
        end else begin
            acc   = (s >= price);
            ins   = !acc;
            c     = acc ? s - price : 0;
            first = D + 1;
        end
        n500  = acc ? c / 5 : 0;
        ncoin = acc ? n500 + c % 5 : 0;
        for (int i = 0; i < ncoin; i++) begin
            coin_t.push_back(first + i * G);
            coin_big.push_back(i < n500);
        end
        if (!acc)            busy_end = -1;
        else if (ncoin == 0) busy_end = D - 1;
        else                 busy_end = coin_t[ncoin - 1] + G - 2;
        len = ((busy_end > 0) ? busy_end : 0) + 4;

        @(negedge clk);
        saldo     = 4'(s);
        seleccion = 2'(k);
        sel_valid = 1'b1;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            e    = 8'h00;
            e[7] = acc && (t == 0);
            e[6:4] = (acc && k < 3 && t < D) ? 3'(1 << k) : 3'b000;
            for (int i = 0; i < ncoin; i++) begin
                if (coin_t[i] == t) begin
                    e[3] = coin_big[i];
                    e[2] = !coin_big[i];
                end
            end
            e[1] = ins && (t == 0);
            e[0] = (t <= busy_end);
            check($sformatf("%s saldo=%0d sel=%0d t=%0d", tag, s, k, t), obs, e);
            saldo     = 4'($urandom_range(0, 15));
            seleccion = 2'($urandom_range(0, 3));
            if (t <= busy_end) sel_valid = hammer ? 1'b1 : 1'($urandom_range(0, 1));
            else               sel_valid = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        saldo     = 4'd0;
        sel_valid = 1'b0;
        seleccion = 2'd0;
        repeat (2) @(negedge clk);
        check("reset_state", obs, 8'h00);
        rst = 1'b0;

        // Directed scenarios; the first one also floods sel_valid while busy
        run_req("exact_pay",     5,  1, 1'b1);
        run_req("mixed_change",  11, 0, 1'b0);
        run_req("insufficient",  6,  2, 1'b0);
        run_req("after_insuf",   15, 2, 1'b1);
        run_req("cancel",        7,  3, 1'b0);
        run_req("cancel_zero",   0,  3, 1'b0);

        // Reset in the middle of paying change
        @(negedge clk);
        saldo     = 4'd15;
        seleccion = 2'd3;
        sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        check("rst_cancel_accept", obs, 8'b1000_0001);
        @(negedge clk);
        check("rst_first_coin", obs, 8'b0000_1001);
        #1 rst = 1'b1;
        #1 check("rst_async_clear", obs, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("rst_no_more_coins t=%0d", t), obs, 8'h00);
        end

        // Randomised requests against the reference timeline
        for (int n = 0; n < 40; n++) begin
            run_req("rand", $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("final_idle", obs, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
